// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decode-stage fields into 32-bit words, buffers
// them in a small FIFO and writes them to consecutive instruction-memory addresses.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [6:0]                 op,
  input  logic [2:0]                 func,
  input  logic [6:0]                 f7,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [19:0]                imm,
  output logic                       mem_req,
  input  logic                       mem_gnt,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       bad_op
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_REG    = 7'h33;

  logic [31:0]       word;
  logic              fmt_ok;
  logic              full;
  logic              push;
  logic              pop;
  logic              accept;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    level_q;
  logic [ADDR_W-1:0] addr_q;
  logic              bad_q;
  logic [31:0]       fifo_mem [DEPTH];

  // Field packing; every bit a format does not use stays zero.
  always_comb begin
    word   = '0;
    fmt_ok = 1'b1;
    case (op)
      OP_LOAD, OP_OPIMM, OP_JALR: word = {imm[11:0], rs1, func, rd, op};
      OP_STORE:                   word = {imm[11:5], rs2, rs1, func, imm[4:0], op};
      OP_BRANCH:                  word = {imm[11], imm[9:4], rs2, rs1, func,
                                          imm[3:0], imm[10], op};
      OP_JAL:                     word = {imm[19], imm[9:0], imm[10], imm[18:11], rd, op};
      OP_LUI, OP_AUIPC:           word = {imm[19:0], rd, op};
      OP_REG:                     word = {f7, rs2, rs1, func, rd, op};
      default:                    fmt_ok = 1'b0;
    endcase
  end

  // Handshake: a field set transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on FIFO fullness and flush, never on in_valid or mem_gnt.
  // Unsupported opcodes still complete the handshake but are dropped.
  assign full     = (level_q == (PTR_W+1)'(DEPTH));
  assign in_ready = !full && !flush;
  assign accept   = in_valid && in_ready;
  assign push     = accept && fmt_ok;
  assign mem_req  = (level_q != '0);
  assign pop      = mem_req && mem_gnt && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      bad_q   <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      bad_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (accept && !fmt_ok) bad_q <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= word;
  end

  assign mem_wdata = mem_req ? fifo_mem[rd_ptr] : '0;
  assign mem_addr  = addr_q;
  assign level     = level_q;
  assign bad_op    = bad_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed RV32I words, an expected-word
// queue checked at every memory write, and a narrow-address instance for wrap.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  op;
  logic [2:0]  func;
  logic [6:0]  f7;
  logic [4:0]  rd, rs1, rs2;
  logic [19:0] imm;
  logic        mem_req;
  logic        mem_gnt;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  level;
  logic        bad_op;

  logic        w_in_ready;
  logic        w_mem_req;
  logic [1:0]  w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic [2:0]  w_level;
  logic        w_bad_op;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [9:0]  exp_addr = '0;
  logic [9:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  logic [1:0]  wlog_addr[$];
  logic [31:0] w_words[6];
  logic [1:0]  w_addrs[6];

  instr_encoder #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .func(func), .f7(f7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .level(level), .bad_op(bad_op)
  );

  instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .op(op), .func(func), .f7(f7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_req(w_mem_req), .mem_gnt(mem_gnt), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
    .level(w_level), .bad_op(w_bad_op)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every accepted write is compared with the oldest expected word
  always @(negedge clk) begin
    if (rst_n && !flush && mem_req && mem_gnt) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("spurious_write", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("wdata", mem_wdata, mon_exp);
      end
      check("waddr", 32'(mem_addr), 32'(exp_addr));
      check("wrap_wdata", w_mem_wdata, mem_wdata);
      exp_addr = exp_addr + 1'b1;
    end
    if (rst_n && !flush && w_mem_req && mem_gnt) wlog_addr.push_back(w_mem_addr);
  end

  // driver tasks: called at posedge+1, return at posedge+1
  task automatic push(input logic [6:0] p_op, input logic [2:0] p_func,
                      input logic [6:0] p_f7, input logic [4:0] p_rd,
                      input logic [4:0] p_rs1, input logic [4:0] p_rs2,
                      input logic [19:0] p_imm, input logic [31:0] p_exp,
                      input bit p_good);
    int waited = 0;
    bit done = 0;
    op = p_op; func = p_func; f7 = p_f7; rd = p_rd;
    rs1 = p_rs1; rs2 = p_rs2; imm = p_imm;
    in_valid = 1'b1;
    while (!done && waited < 50) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      if (!done) waited++;
    end
    #1;
    in_valid = 1'b0;
    if (!done) check("push_timeout", 32'd0, 32'd1);
    else if (p_good) exp_q.push_back(p_exp);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    exp_addr = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (level != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_level", 32'(level), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    wlog_addr.delete();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; mem_gnt = 1'b0;
    op = '0; func = '0; f7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_bad_op", 32'(bad_op), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addi x1,x0,5 with grant held high
    mem_gnt = 1'b1;
    push(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 20'h00005, 32'h00500093, 1);
    check("addi_req", 32'(mem_req), 32'd1);
    check("addi_wdata", mem_wdata, 32'h00500093);
    check("addi_addr", 32'(mem_addr), 32'd0);
    check("addi_level", 32'(level), 32'd1);
    @(posedge clk);
    #1;
    check("addi_level_after", 32'(level), 32'd0);
    check("addi_req_after", 32'(mem_req), 32'd0);

    // back-to-back S, B, J, U
    do_flush();
    clear_logs();
    push(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 20'h00008, 32'h0020A423, 1);
    push(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 20'h00FFE, 32'hFE000EE3, 1);
    push(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 20'h00004, 32'h008000EF, 1);
    push(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 20'h12345, 32'h123452B7, 1);
    drain();
    check("b2b_count", 32'(log_addr.size()), 32'd4);
    if (log_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) check("b2b_addr", 32'(log_addr[i]), 32'(i));
      check("b2b_sw", log_data[0], 32'h0020A423);
      check("b2b_beq", log_data[1], 32'hFE000EE3);
      check("b2b_jal", log_data[2], 32'h008000EF);
      check("b2b_lui", log_data[3], 32'h123452B7);
      for (int i = 1; i < 4; i++) check("b2b_consecutive", 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
    end

    // backpressure: grant low, five pushes
    do_flush();
    clear_logs();
    mem_gnt = 1'b0;
    push(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 20'h00005, 32'h00500093, 1);
    push(7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 20'h00005, 32'h00500113, 1);
    push(7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 20'h00005, 32'h00500193, 1);
    push(7'h13, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 20'h00005, 32'h00500213, 1);
    check("bp_level_full", 32'(level), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_req", 32'(mem_req), 32'd1);
    op = 7'h13; func = 3'd0; f7 = 7'd0; rd = 5'd5; rs1 = 5'd0; rs2 = 5'd0; imm = 20'h00005;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      check("bp_hold_level", 32'(level), 32'd4);
      check("bp_hold_addr", 32'(mem_addr), 32'd0);
      check("bp_hold_wdata", mem_wdata, 32'h00500093);
    end
    @(posedge clk);
    #1;
    mem_gnt = 1'b1;
    push(7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 20'h00005, 32'h00500293, 1);
    check("bp_level_pushpop", 32'(level), 32'd3);
    drain();
    check("bp_count", 32'(log_addr.size()), 32'd5);
    if (log_addr.size() == 5)
      for (int i = 0; i < 5; i++) check("bp_addr", 32'(log_addr[i]), 32'(i));

    // unsupported opcode
    do_flush();
    clear_logs();
    push(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 20'h00005, 32'h0, 0);
    check("bad_set", 32'(bad_op), 32'd1);
    check("bad_wrap_set", 32'(w_bad_op), 32'd1);
    check("bad_level", 32'(level), 32'd0);
    push(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 20'h00005, 32'h00500093, 1);
    drain();
    check("bad_count", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) begin
      check("bad_addi_addr", 32'(log_addr[0]), 32'd0);
      check("bad_addi_data", log_data[0], 32'h00500093);
    end
    check("bad_sticky", 32'(bad_op), 32'd1);
    mem_gnt = 1'b0;
    push(7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 20'h00005, 32'h00500113, 1);
    mem_gnt = 1'b1;
    do_flush();
    check("flush_bad_op", 32'(bad_op), 32'd0);
    check("flush_addr", 32'(mem_addr), 32'd0);
    check("flush_level", 32'(level), 32'd0);
    check("flush_req", 32'(mem_req), 32'd0);

    // address wrap on the 2-bit instance; unused fields carry garbage
    clear_logs();
    w_words = '{32'hFFF12303, 32'h00008067, 32'hFFFFF397,
                32'h00500093, 32'h402081B3, 32'h0020A423};
    w_addrs = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    push(7'h03, 3'd2, 7'h7F, 5'd6, 5'd2, 5'h1F, 20'hABFFF, w_words[0], 1);
    push(7'h67, 3'd0, 7'd0,  5'd0, 5'd1, 5'd0,  20'h00000, w_words[1], 1);
    push(7'h17, 3'd7, 7'h7F, 5'd7, 5'h1F, 5'h1F, 20'hFFFFF, w_words[2], 1);
    push(7'h13, 3'd0, 7'h55, 5'd1, 5'd0, 5'h1F, 20'h00005, w_words[3], 1);
    push(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2,  20'hFFFFF, w_words[4], 1);
    push(7'h23, 3'd2, 7'h7F, 5'h1F, 5'd1, 5'd2, 20'h00008, w_words[5], 1);
    drain();
    check("wrap_count", 32'(wlog_addr.size()), 32'd6);
    if (wlog_addr.size() == 6)
      for (int i = 0; i < 6; i++) check("wrap_addr", 32'(wlog_addr[i]), 32'(w_addrs[i]));
    if (log_data.size() == 6)
      for (int i = 0; i < 6; i++) check("wrap_word", log_data[i], w_words[i]);

    // asynchronous reset with three words pending
    mem_gnt = 1'b0;
    push(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 20'h00005, 32'h00500093, 1);
    push(7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 20'h00005, 32'h00500113, 1);
    push(7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 20'h00005, 32'h00500193, 1);
    check("arst_level_before", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(mem_req), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_wrap_level", 32'(w_level), 32'd0);
    check("arst_wdata", mem_wdata, 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_wrap_in_ready", 32'(w_in_ready), 32'd1);
    exp_q.delete();
    exp_addr = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    mem_gnt = 1'b1;
    push(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 20'h12345, 32'h123452B7, 1);
    drain();
    check("arst_post_count", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) begin
      check("arst_post_addr", 32'(log_addr[0]), 32'd0);
      check("arst_post_data", log_data[0], 32'h123452B7);
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
